// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 byte-stream PKCS#7 padder and unpadder.
package sm4_pkg;

  localparam int SM4_BLOCK_BYTES = 16;

  typedef enum logic {
    PASS = 1'b0,
    PAD  = 1'b1
  } pad_state_e;

  // cnt is the number of bytes already seen in the current block, before the last byte.
  function automatic logic [4:0] pkcs7_len(input logic [3:0] cnt);
    logic [3:0] nxt;
    nxt = cnt + 4'd1;
    return 5'd16 - {1'b0, nxt};
  endfunction

endpackage

// File: rtl/sm4_pkcs7_pad_axis8_if.sv
// 8-bit AXI-Stream bundle with a tuser sideband, as seen by the padder.
interface sm4_pkcs7_pad_axis8_if #(
  parameter int TUSER_W = 8
);
  logic [7:0]         tdata;
  logic               tvalid;
  logic               tlast;
  logic [TUSER_W-1:0] tuser;
  logic               tready;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/sm4_pkcs7_pad_axis8.sv
// Appends PKCS#7 padding to 8-bit AXI-Stream packets so each packet is a whole
// number of 16-byte SM4 blocks; data bytes pass through one output register.
module sm4_pkcs7_pad_axis8
  import sm4_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int TUSER_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pad_en,
  sm4_pkcs7_pad_axis8_if.slave         s_axis,
  sm4_pkcs7_pad_axis8_if.master        m_axis
);

  if (BLOCK_BYTES != SM4_BLOCK_BYTES) begin : g_bad_block
    $error("sm4_pkcs7_pad_axis8 supports only 16-byte blocks");
  end

  pad_state_e         state;
  pad_state_e         state_nxt;
  logic [3:0]         cnt;
  logic               first;
  logic               pad_act;
  logic [4:0]         rem;
  logic [4:0]         pad_len;
  logic [TUSER_W-1:0] user_q;

  logic [7:0]         tdata_p0;
  logic               vld_p0;
  logic               tlast_p0;
  logic [TUSER_W-1:0] tuser_p0;

  logic reg_free;
  logic in_hs;
  logic pad_now;
  logic pad_start;
  logic pad_step;
  logic pad_done;

  assign reg_free  = !vld_p0 || m_axis.tready;
  assign s_axis.tready = (state == PASS) && reg_free && !rst;
  assign in_hs     = s_axis.tvalid && s_axis.tready;
  // The packet's padding decision is taken from live pad_en only on its first byte.
  assign pad_now   = first ? pad_en : pad_act;
  assign pad_start = in_hs && s_axis.tlast && pad_now;
  assign pad_step  = (state == PAD) && reg_free;
  assign pad_done  = pad_step && (rem == 5'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      PASS:    if (pad_start) state_nxt = PAD;
      PAD:     if (pad_done)  state_nxt = PASS;
      default: state_nxt = PASS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PASS;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      first   <= 1'b1;
      pad_act <= 1'b0;
      rem     <= 5'd0;
    end else begin
      if (in_hs) begin
        if (s_axis.tlast && !pad_now) begin
          cnt   <= 4'd0;
          first <= 1'b1;
        end else begin
          cnt   <= cnt + 4'd1;
          first <= 1'b0;
        end
        if (first) pad_act <= pad_en;
      end else if (pad_done) begin
        cnt   <= 4'd0;
        first <= 1'b1;
      end

      if (pad_start)     rem <= pkcs7_len(cnt);
      else if (pad_step) rem <= rem - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs && first) user_q  <= s_axis.tuser;
    if (pad_start)      pad_len <= pkcs7_len(cnt);
  end

  // ---- output register stage p0 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      tdata_p0 <= 8'd0;
      tlast_p0 <= 1'b0;
      tuser_p0 <= '0;
    end else if (in_hs) begin
      vld_p0   <= 1'b1;
      tdata_p0 <= s_axis.tdata;
      tuser_p0 <= s_axis.tuser;
      tlast_p0 <= s_axis.tlast && !pad_now;
    end else if (pad_step) begin
      vld_p0   <= 1'b1;
      tdata_p0 <= {3'b000, pad_len};
      tuser_p0 <= user_q;
      tlast_p0 <= (rem == 5'd1);
    end else if (m_axis.tready) begin
      vld_p0   <= 1'b0;
    end
  end

  assign m_axis.tdata  = tdata_p0;
  assign m_axis.tvalid = vld_p0;
  assign m_axis.tlast  = tlast_p0;
  assign m_axis.tuser  = tuser_p0;

endmodule
